// File: rtl/vtg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vtg_pkg
//  Description : Shared constants for the raster timing generator: load FSM
//                encoding, 720p reset timing and the per-axis legality check.
//  Revision    : 1.0 - initial release
// ============================================================================
package vtg_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    localparam int unsigned VTG_DEF_H_TOTAL  = 1650;
    localparam int unsigned VTG_DEF_H_SYNC   = 40;
    localparam int unsigned VTG_DEF_H_BPORCH = 220;
    localparam int unsigned VTG_DEF_H_RES    = 1280;
    localparam int unsigned VTG_DEF_V_TOTAL  = 750;
    localparam int unsigned VTG_DEF_V_SYNC   = 5;
    localparam int unsigned VTG_DEF_V_BPORCH = 20;
    localparam int unsigned VTG_DEF_V_RES    = 720;

    // With res nonzero, total > sync+bporch+res-1 is the same as total >= sum.
    function automatic logic vtg_axis_legal(input int unsigned total,
                                            input int unsigned sync,
                                            input int unsigned bporch,
                                            input int unsigned res);
        return (sync != 0) && (res != 0) && (total >= sync + bporch + res);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vtg_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : vtg_delay_line
//  Description : Parametrised shift register with reset value; depth 0 is a
//                straight wire.
//  Revision    : 1.0 - initial release
// ============================================================================
module vtg_delay_line #(
    parameter int unsigned     W       = 1,
    parameter int unsigned     DEPTH   = 1,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         I_clk,
    input  logic         I_rst_n,
    input  logic [W-1:0] I_d,
    output logic [W-1:0] O_q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign O_q = I_d;
        end else begin : g_pipe
            logic [DEPTH-1:0][W-1:0] stage_q;
            logic [DEPTH-1:0][W-1:0] stage_d;

            always_comb begin
                stage_d[0] = I_d;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            always_ff @(posedge I_clk or negedge I_rst_n) begin
                if (!I_rst_n) begin
                    stage_q <= {DEPTH{RST_VAL}};
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign O_q = stage_q[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : video_timing_gen
//  Description : Runtime-programmable raster timing generator with shadowed,
//                frame-synchronous mode switching and delayed DE/HS/VS.
//  Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int unsigned CW           = 12,
    parameter int unsigned FCW          = 10,
    parameter int unsigned DELAY        = 2,
    parameter int unsigned DEF_H_TOTAL  = VTG_DEF_H_TOTAL,
    parameter int unsigned DEF_H_SYNC   = VTG_DEF_H_SYNC,
    parameter int unsigned DEF_H_BPORCH = VTG_DEF_H_BPORCH,
    parameter int unsigned DEF_H_RES    = VTG_DEF_H_RES,
    parameter int unsigned DEF_V_TOTAL  = VTG_DEF_V_TOTAL,
    parameter int unsigned DEF_V_SYNC   = VTG_DEF_V_SYNC,
    parameter int unsigned DEF_V_BPORCH = VTG_DEF_V_BPORCH,
    parameter int unsigned DEF_V_RES    = VTG_DEF_V_RES,
    parameter bit          DEF_HS_POL   = 1'b1,
    parameter bit          DEF_VS_POL   = 1'b1
) (
    input  logic           I_clk,
    input  logic           I_rst_n,
    input  logic           I_enable,
    input  logic [CW-1:0]  I_cfg_h_total,
    input  logic [CW-1:0]  I_cfg_h_sync,
    input  logic [CW-1:0]  I_cfg_h_bporch,
    input  logic [CW-1:0]  I_cfg_h_res,
    input  logic [CW-1:0]  I_cfg_v_total,
    input  logic [CW-1:0]  I_cfg_v_sync,
    input  logic [CW-1:0]  I_cfg_v_bporch,
    input  logic [CW-1:0]  I_cfg_v_res,
    input  logic           I_cfg_hs_pol,
    input  logic           I_cfg_vs_pol,
    input  logic           I_cfg_load,
    output logic           O_cfg_pending,
    output logic           O_cfg_ack,
    output logic           O_cfg_err,
    output logic           O_de,
    output logic           O_hs,
    output logic           O_vs,
    output logic [CW-1:0]  O_x,
    output logic [CW-1:0]  O_y,
    output logic           O_line_start,
    output logic           O_frame_start,
    output logic [FCW-1:0] O_frame_cnt
);

    typedef struct packed {
        logic [CW-1:0] h_total;
        logic [CW-1:0] h_sync;
        logic [CW-1:0] h_bporch;
        logic [CW-1:0] h_res;
        logic [CW-1:0] v_total;
        logic [CW-1:0] v_sync;
        logic [CW-1:0] v_bporch;
        logic [CW-1:0] v_res;
        logic          hs_pol;
        logic          vs_pol;
    } timing_t;

    localparam timing_t DEF_SET = '{
        h_total:  CW'(DEF_H_TOTAL),
        h_sync:   CW'(DEF_H_SYNC),
        h_bporch: CW'(DEF_H_BPORCH),
        h_res:    CW'(DEF_H_RES),
        v_total:  CW'(DEF_V_TOTAL),
        v_sync:   CW'(DEF_V_SYNC),
        v_bporch: CW'(DEF_V_BPORCH),
        v_res:    CW'(DEF_V_RES),
        hs_pol:   DEF_HS_POL,
        vs_pol:   DEF_VS_POL
    };

    // Sync bus ordering is {de, hs, vs}; idle level is the inactive polarity.
    localparam logic [2:0] SYNC_RST = {1'b0, !DEF_HS_POL, !DEF_VS_POL};

    logic [0:0]     state_q, state_d;
    timing_t        act_q, act_d;
    timing_t        shd_q, shd_d;
    logic [CW-1:0]  h_q, h_d;
    logic [CW-1:0]  v_q, v_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic           cfg_ack_q, cfg_ack_d;
    logic           cfg_err_q, cfg_err_d;
    logic [CW-1:0]  x_q, x_d;
    logic [CW-1:0]  y_q, y_d;
    logic           line_start_q, line_start_d;
    logic           frame_start_q, frame_start_d;
    logic [2:0]     sync_q, sync_d;
    logic [2:0]     w_sync_dly;

    timing_t        w_req;
    logic [CW:0]    w_hs0, w_hend, w_vs0, w_vend;
    logic           w_line_end, w_frame_wrap;
    logic           w_de, w_hs_act, w_vs_act;
    logic           w_cfg_ok, w_apply;

    assign w_req = '{
        h_total:  I_cfg_h_total,
        h_sync:   I_cfg_h_sync,
        h_bporch: I_cfg_h_bporch,
        h_res:    I_cfg_h_res,
        v_total:  I_cfg_v_total,
        v_sync:   I_cfg_v_sync,
        v_bporch: I_cfg_v_bporch,
        v_res:    I_cfg_v_res,
        hs_pol:   I_cfg_hs_pol,
        vs_pol:   I_cfg_vs_pol
    };

    assign w_cfg_ok = vtg_axis_legal(32'(I_cfg_h_total), 32'(I_cfg_h_sync),
                                     32'(I_cfg_h_bporch), 32'(I_cfg_h_res))
                   && vtg_axis_legal(32'(I_cfg_v_total), 32'(I_cfg_v_sync),
                                     32'(I_cfg_v_bporch), 32'(I_cfg_v_res));

    assign w_hs0  = {1'b0, act_q.h_sync} + {1'b0, act_q.h_bporch};
    assign w_hend = w_hs0 + {1'b0, act_q.h_res};
    assign w_vs0  = {1'b0, act_q.v_sync} + {1'b0, act_q.v_bporch};
    assign w_vend = w_vs0 + {1'b0, act_q.v_res};

    assign w_line_end   = (h_q == act_q.h_total - CW'(1));
    assign w_frame_wrap = I_enable && w_line_end && (v_q == act_q.v_total - CW'(1));

    assign w_hs_act = I_enable && (h_q < act_q.h_sync);
    assign w_vs_act = I_enable && (v_q < act_q.v_sync);
    assign w_de     = I_enable
                   && ({1'b0, h_q} >= w_hs0) && ({1'b0, h_q} < w_hend)
                   && ({1'b0, v_q} >= w_vs0) && ({1'b0, v_q} < w_vend);

    // Apply is decided from the registered state, so a load landing on the
    // wrap cycle waits for the following wrap.
    assign w_apply = (state_q == ST_PEND) && (w_frame_wrap || !I_enable);

    always_comb begin
        state_d     = state_q;
        act_d       = act_q;
        shd_d       = shd_q;
        cfg_ack_d   = 1'b0;
        cfg_err_d   = 1'b0;
        h_d         = h_q;
        v_d         = v_q;
        frame_cnt_d = frame_cnt_q;

        if (!I_enable) begin
            h_d = '0;
            v_d = '0;
        end else if (w_line_end) begin
            h_d = '0;
            v_d = (v_q == act_q.v_total - CW'(1)) ? '0 : v_q + 1'b1;
        end else begin
            h_d = h_q + 1'b1;
        end

        if (w_frame_wrap) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end

        if (w_apply) begin
            act_d     = shd_q;
            cfg_ack_d = 1'b1;
            state_d   = ST_IDLE;
        end

        if (I_cfg_load) begin
            if (w_cfg_ok) begin
                shd_d   = w_req;
                state_d = ST_PEND;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    always_comb begin
        x_d           = w_de ? (h_q - w_hs0[CW-1:0]) : '0;
        y_d           = w_de ? (v_q - w_vs0[CW-1:0]) : '0;
        line_start_d  = w_de && ({1'b0, h_q} == w_hs0);
        frame_start_d = w_de && ({1'b0, h_q} == w_hs0) && ({1'b0, v_q} == w_vs0);
        sync_d        = {w_de, w_hs_act ~^ act_q.hs_pol, w_vs_act ~^ act_q.vs_pol};
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q       <= ST_IDLE;
            act_q         <= DEF_SET;
            shd_q         <= DEF_SET;
            h_q           <= '0;
            v_q           <= '0;
            frame_cnt_q   <= '0;
            cfg_ack_q     <= 1'b0;
            cfg_err_q     <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            sync_q        <= SYNC_RST;
        end else begin
            state_q       <= state_d;
            act_q         <= act_d;
            shd_q         <= shd_d;
            h_q           <= h_d;
            v_q           <= v_d;
            frame_cnt_q   <= frame_cnt_d;
            cfg_ack_q     <= cfg_ack_d;
            cfg_err_q     <= cfg_err_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            sync_q        <= sync_d;
        end
    end

    vtg_delay_line #(
        .W       (3),
        .DEPTH   (DELAY),
        .RST_VAL (SYNC_RST)
    ) u_sync_dly (
        .I_clk   (I_clk),
        .I_rst_n (I_rst_n),
        .I_d     (sync_q),
        .O_q     (w_sync_dly)
    );

    assign {O_de, O_hs, O_vs} = w_sync_dly;
    assign O_x                = x_q;
    assign O_y                = y_q;
    assign O_line_start       = line_start_q;
    assign O_frame_start      = frame_start_q;
    assign O_frame_cnt        = frame_cnt_q;
    assign O_cfg_pending      = (state_q == ST_PEND);
    assign O_cfg_ack          = cfg_ack_q;
    assign O_cfg_err          = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_video_timing_gen
//  Description : Directed + random bench for video_timing_gen against a
//                position-in-frame reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

    localparam int TB_DELAY = 2;

    typedef struct packed {
        int ht; int hs; int hb; int hr;
        int vt; int vs; int vb; int vr;
        bit hp; bit vp;
    } cfg_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    cfg_t        req;

    logic        o_pending, o_ack, o_err, o_de, o_hs, o_vs, o_ls, o_fs;
    logic [11:0] o_x, o_y;
    logic [9:0]  o_fcnt;

    cfg_t        m_act, m_shd;
    bit          m_pend;
    int          m_pos;
    int          m_fcnt;
    logic [2:0]  q_sync[$];
    int          n_chk;
    int          n_fail;

    always #5 clk = ~clk;

    video_timing_gen #(.DELAY(TB_DELAY)) dut (
        .I_clk          (clk),
        .I_rst_n        (rst_n),
        .I_enable       (en),
        .I_cfg_h_total  (12'(req.ht)),
        .I_cfg_h_sync   (12'(req.hs)),
        .I_cfg_h_bporch (12'(req.hb)),
        .I_cfg_h_res    (12'(req.hr)),
        .I_cfg_v_total  (12'(req.vt)),
        .I_cfg_v_sync   (12'(req.vs)),
        .I_cfg_v_bporch (12'(req.vb)),
        .I_cfg_v_res    (12'(req.vr)),
        .I_cfg_hs_pol   (req.hp),
        .I_cfg_vs_pol   (req.vp),
        .I_cfg_load     (load),
        .O_cfg_pending  (o_pending),
        .O_cfg_ack      (o_ack),
        .O_cfg_err      (o_err),
        .O_de           (o_de),
        .O_hs           (o_hs),
        .O_vs           (o_vs),
        .O_x            (o_x),
        .O_y            (o_y),
        .O_line_start   (o_ls),
        .O_frame_start  (o_fs),
        .O_frame_cnt    (o_fcnt)
    );

    function automatic cfg_t mk(int ht, int hs, int hb, int hr,
                                int vt, int vs, int vb, int vr, bit hp, bit vp);
        cfg_t c;
        c.ht = ht; c.hs = hs; c.hb = hb; c.hr = hr;
        c.vt = vt; c.vs = vs; c.vb = vb; c.vr = vr;
        c.hp = hp; c.vp = vp;
        return c;
    endfunction

    function automatic bit legal(cfg_t c);
        return c.hs != 0 && c.hr != 0 && c.vs != 0 && c.vr != 0
            && c.ht > c.hs + c.hb + c.hr - 1 && c.vt > c.vs + c.vb + c.vr - 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_act  = mk(1650, 40, 220, 1280, 750, 5, 20, 720, 1'b1, 1'b1);
        m_shd  = m_act;
        m_pend = 1'b0;
        m_pos  = 0;
        m_fcnt = 0;
        q_sync.delete();
        for (int i = 0; i < TB_DELAY; i++) q_sync.push_back(3'b000);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_sync"},    32'({o_de, o_hs, o_vs}), 0);
        chk({tag, "_xy"},      32'({o_x, o_y}), 0);
        chk({tag, "_strobes"}, 32'({o_ls, o_fs, o_ack, o_err}), 0);
        chk({tag, "_pending"}, 32'(o_pending), 0);
        chk({tag, "_fcnt"},    32'(o_fcnt), 0);
    endtask

    // One clock: predict from the raster position, advance, then compare.
    task automatic tick();
        int h, v, hs0, vs0, ex_x, ex_y;
        bit de, ls, fs, wrap, apply, ok;
        logic [2:0] s, ex_s;
        h    = m_pos % m_act.ht;
        v    = m_pos / m_act.ht;
        hs0  = m_act.hs + m_act.hb;
        vs0  = m_act.vs + m_act.vb;
        de   = en && h >= hs0 && h < hs0 + m_act.hr && v >= vs0 && v < vs0 + m_act.vr;
        ex_x = de ? h - hs0 : 0;
        ex_y = de ? v - vs0 : 0;
        ls   = de && h == hs0;
        fs   = ls && v == vs0;
        s    = {de, (en && h < m_act.hs) ? m_act.hp : !m_act.hp,
                    (en && v < m_act.vs) ? m_act.vp : !m_act.vp};
        wrap  = en && m_pos == m_act.ht * m_act.vt - 1;
        apply = m_pend && (wrap || !en);
        ok    = legal(req);
        if (apply) begin
            m_act  = m_shd;
            m_pend = 1'b0;
        end
        if (load && ok) begin
            m_shd  = req;
            m_pend = 1'b1;
        end
        if (wrap) m_fcnt = (m_fcnt + 1) % 1024;
        m_pos = (!en || wrap) ? 0 : m_pos + 1;
        q_sync.push_back(s);
        ex_s = q_sync.pop_front();

        @(posedge clk);
        #1;
        chk("x",           32'(o_x), ex_x);
        chk("y",           32'(o_y), ex_y);
        chk("line_start",  32'(o_ls), 32'(ls));
        chk("frame_start", 32'(o_fs), 32'(fs));
        chk("de_hs_vs",    32'({o_de, o_hs, o_vs}), 32'(ex_s));
        chk("cfg_ack",     32'(o_ack), 32'(apply));
        chk("cfg_err",     32'(o_err), 32'(load && !ok));
        chk("cfg_pending", 32'(o_pending), 32'(m_pend));
        chk("frame_cnt",   32'(o_fcnt), m_fcnt);
    endtask

    // Tick until the next clock is the frame-wrap cycle.
    task automatic wait_wrap();
        int guard;
        guard = 0;
        while (!(en && m_pos == m_act.ht * m_act.vt - 1) && guard < 4000) begin
            tick();
            guard++;
        end
        if (guard >= 4000) begin
            n_chk++;
            n_fail++;
            $error("FAIL wrap_timeout observed=%0d expected=%0d", m_pos, m_act.ht * m_act.vt - 1);
        end
    endtask

    initial begin
        cfg_t c;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        en     = 1'b0;
        load   = 1'b0;
        req    = mk(1650, 40, 220, 1280, 750, 5, 20, 720, 1'b1, 1'b1);
        model_reset();
        #3;
        check_reset("reset_init");
        #9;
        rst_n = 1'b1;
        repeat (3) tick();

        // Small raster loaded while disabled, then run three frames.
        req  = mk(10, 2, 2, 4, 6, 1, 1, 3, 1'b1, 1'b1);
        load = 1'b1; tick(); load = 1'b0;
        tick();
        en = 1'b1;
        repeat (185) tick();

        // Mid-frame legal load: wider line takes over at the wrap.
        req.ht = 12; req.hr = 6;
        load = 1'b1; tick(); load = 1'b0;
        repeat (100) tick();

        // Illegal load leaves everything as it was.
        req = mk(8, 2, 2, 6, 6, 1, 1, 3, 1'b1, 1'b1);
        load = 1'b1; tick(); load = 1'b0;
        repeat (20) tick();

        // Load exactly on the wrap cycle, then a second load while pending.
        wait_wrap();
        req  = mk(10, 2, 2, 4, 6, 1, 1, 3, 1'b1, 1'b1);
        load = 1'b1; tick(); load = 1'b0;
        repeat (5) tick();
        req  = mk(11, 1, 3, 5, 7, 2, 1, 3, 1'b0, 1'b1);
        load = 1'b1; tick(); load = 1'b0;
        wait_wrap();
        repeat (160) tick();

        // Random configurations, load timing and enable drops.
        for (int it = 0; it < 30; it++) begin
            c.hs = $urandom_range(0, 3);
            c.hb = $urandom_range(0, 3);
            c.hr = $urandom_range(0, 6);
            c.ht = $urandom_range(2, 16);
            c.vs = $urandom_range(0, 2);
            c.vb = $urandom_range(0, 2);
            c.vr = $urandom_range(0, 5);
            c.vt = $urandom_range(2, 12);
            c.hp = 1'($urandom_range(0, 1));
            c.vp = 1'($urandom_range(0, 1));
            req  = c;
            load = 1'b1; tick(); load = 1'b0;
            repeat ($urandom_range(0, 200)) tick();
            if ($urandom_range(0, 3) == 0) begin
                en = 1'b0;
                repeat ($urandom_range(1, 4)) tick();
                en = 1'b1;
            end
        end

        // Asynchronous reset while a load is pending, mid-line.
        req  = mk(10, 2, 2, 4, 6, 1, 1, 3, 1'b1, 1'b1);
        wait_wrap();
        repeat (3) tick();
        load = 1'b1; tick(); load = 1'b0;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("reset_mid");
        model_reset();
        #2;
        rst_n = 1'b1;
        repeat (60) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
